// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and constants for the tri-state bus arbiter.
// Holds the FSM state encoding, the default configuration constants and
// a helper function that turns a requester index into a one-hot vector.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_TURNAROUND = 1;
    localparam int DEF_MAX_HOLD   = 16;
    localparam int MAX_N_REQ      = 16;

    // Index-to-one-hot conversion, sized for the largest supported requester count.
    function automatic logic [MAX_N_REQ-1:0] onehot_idx(input logic [3:0] idx);
        logic [MAX_N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches req upward starting one position above the last owner, wrapping
// past the top, and reports the first set bit.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest set bit above 'last' wins.
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = (int'(last) + k) % N_REQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus.
// Keeps the bufif1 enables one-hot, holds a grant until its owner drops the
// request, and inserts an all-off turnaround gap between owners.
// Optional forced release after MAX_HOLD cycles: define BUS_ARB_TIMEOUT_EN.
// Reset is asynchronous so the enables drop immediately, without a clock.
module tristate_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int TURNAROUND = DEF_TURNAROUND,
    parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         drv_en,
    output logic                     bus_busy,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     timeout_pulse
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TW    = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    state_t             r_state, w_state_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [TW-1:0]      r_turn_cnt, w_turn_nxt;
    logic               w_pick_vld;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [N_REQ-1:0]   w_pick_oh;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .last  (r_owner),
        .valid (w_pick_vld),
        .idx   (w_pick_idx)
    );

    assign w_pick_oh = N_REQ'(onehot_idx(4'(w_pick_idx)));

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] r_hold_cnt, w_hold_nxt;
    logic          r_tpulse, w_tpulse_nxt;
    logic          w_others;

    // Another requester is waiting; only then may the owner be forced off.
    assign w_others = |(req & ~r_grant);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and next register values; a release always passes through TURN.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_turn_nxt  = r_turn_cnt;
`ifdef BUS_ARB_TIMEOUT_EN
        w_hold_nxt   = r_hold_cnt;
        w_tpulse_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = OWN;
                    w_grant_nxt = w_pick_oh;
                    w_owner_nxt = w_pick_idx;
`ifdef BUS_ARB_TIMEOUT_EN
                    w_hold_nxt  = '0;
`endif
                end
            end
            OWN: begin
                if (!req[r_owner]) begin
                    w_state_nxt = TURN;
                    w_grant_nxt = '0;
                    w_turn_nxt  = '0;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if ((r_hold_cnt == HW'(MAX_HOLD - 1)) && w_others) begin
                    w_state_nxt  = TURN;
                    w_grant_nxt  = '0;
                    w_turn_nxt   = '0;
                    w_tpulse_nxt = 1'b1;
                end else if (r_hold_cnt != HW'(MAX_HOLD - 1)) begin
                    // Saturate so a sole requester can hold forever without wrapping.
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
`endif
            end
            TURN: begin
                if (r_turn_cnt == TW'(TURNAROUND - 1)) w_state_nxt = IDLE;
                else                                   w_turn_nxt  = r_turn_cnt + 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Grant, owner and turnaround registers; owner resets to the top index so requester 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_owner    <= IDX_W'(N_REQ - 1);
            r_turn_cnt <= '0;
        end else begin
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_turn_cnt <= w_turn_nxt;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Hold counter and the one-cycle forced-release pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
            r_tpulse   <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_nxt;
            r_tpulse   <= w_tpulse_nxt;
        end
    end

    assign timeout_pulse = r_tpulse;
`else
    // Without the timeout the pulse is constant low (MAX_HOLD is never negative).
    assign timeout_pulse = (MAX_HOLD < 0);
`endif

    assign grant    = r_grant;
    assign drv_en   = (r_state == OWN) ? r_grant : '0;
    assign bus_busy = (r_state != IDLE);
    assign owner_id = r_owner;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed testbench for tristate_bus_arbiter (N_REQ=4, TURNAROUND=1, MAX_HOLD=4).
// Covers the timeout build when compiled with BUS_ARB_TIMEOUT_EN.
module tb_tristate_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [3:0] drv_en;
    logic       bus_busy;
    logic [1:0] owner_id;
    logic       timeout_pulse;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tristate_bus_arbiter #(
        .N_REQ      (4),
        .TURNAROUND (1),
        .MAX_HOLD   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .grant         (grant),
        .drv_en        (drv_en),
        .bus_busy      (bus_busy),
        .owner_id      (owner_id),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        step();
        step();
        total_cnt++;
        if ({grant, drv_en, bus_busy, owner_id, timeout_pulse} !== {4'b0, 4'b0, 1'b0, 2'd3, 1'b0})
            $display("FAIL reset_state: grant=%b drv_en=%b busy=%b owner=%0d tp=%b expected 0000 0000 0 3 0",
                     grant, drv_en, bus_busy, owner_id, timeout_pulse);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (bus_busy !== 1'b0)
            $display("FAIL reset_idle: busy=%b expected 0", bus_busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_own();
        req = 4'b0001;
        step();
        total_cnt++;
        if (drv_en !== 4'b0001)
            $display("FAIL mid_own_grant: drv_en=%b expected 0001", drv_en);
        else pass_cnt++;
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({drv_en, grant, owner_id, bus_busy} !== {4'b0, 4'b0, 2'd3, 1'b0})
            $display("FAIL async_reset: drv_en=%b grant=%b owner=%0d busy=%b expected 0000 0000 3 0",
                     drv_en, grant, owner_id, bus_busy);
        else pass_cnt++;
        #1;
        req   = 4'b0000;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        req = 4'b0100;
        step();
        total_cnt++;
        if ({grant, drv_en, owner_id, bus_busy} !== {4'b0100, 4'b0100, 2'd2, 1'b1})
            $display("FAIL single_grant: grant=%b drv_en=%b owner=%0d busy=%b expected 0100 0100 2 1",
                     grant, drv_en, owner_id, bus_busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if (drv_en !== 4'b0100)
            $display("FAIL single_hold: drv_en=%b expected 0100", drv_en);
        else pass_cnt++;
        req = 4'b0000;
        step();
        total_cnt++;
        if ({grant, drv_en, bus_busy} !== {4'b0, 4'b0, 1'b1})
            $display("FAIL single_turn: grant=%b drv_en=%b busy=%b expected 0000 0000 1", grant, drv_en, bus_busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({drv_en, bus_busy, owner_id} !== {4'b0, 1'b0, 2'd2})
            $display("FAIL single_idle: drv_en=%b busy=%b owner=%0d expected 0000 0 2", drv_en, bus_busy, owner_id);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_oh;
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << order[k];
            total_cnt++;
            if ({drv_en, owner_id} !== {exp_oh, 2'(order[k])})
                $display("FAIL rr_grant_%0d: drv_en=%b owner=%0d expected %b %0d",
                         k, drv_en, owner_id, exp_oh, order[k]);
            else pass_cnt++;
            if (k < 4) begin
                req = 4'b1111 & ~exp_oh;
                step();
                total_cnt++;
                if (drv_en !== 4'b0000)
                    $display("FAIL rr_gap1_%0d: drv_en=%b expected 0000", k, drv_en);
                else pass_cnt++;
                req = 4'b1111;
                step();
                total_cnt++;
                if (drv_en !== 4'b0000)
                    $display("FAIL rr_gap2_%0d: drv_en=%b expected 0000", k, drv_en);
                else pass_cnt++;
                step();
            end
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1000;
        step();
        req = 4'b0000;
        step();
        step();
        total_cnt++;
        if ({owner_id, bus_busy} !== {2'd3, 1'b0})
            $display("FAIL wrap_setup: owner=%0d busy=%b expected 3 0", owner_id, bus_busy);
        else pass_cnt++;
        req = 4'b1001;
        step();
        total_cnt++;
        if (drv_en !== 4'b0001)
            $display("FAIL wrap_grant0: drv_en=%b expected 0001", drv_en);
        else pass_cnt++;
        req = 4'b1000;
        step();
        step();
        step();
        total_cnt++;
        if ({drv_en, owner_id} !== {4'b1000, 2'd3})
            $display("FAIL wrap_grant3: drv_en=%b owner=%0d expected 1000 3", drv_en, owner_id);
        else pass_cnt++;
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0101;
`ifdef BUS_ARB_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++;
            if ({drv_en, timeout_pulse} !== {4'b0001, 1'b0})
                $display("FAIL to_hold_%0d: drv_en=%b tp=%b expected 0001 0", k, drv_en, timeout_pulse);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if ({drv_en, timeout_pulse, bus_busy} !== {4'b0000, 1'b1, 1'b1})
            $display("FAIL to_release: drv_en=%b tp=%b busy=%b expected 0000 1 1", drv_en, timeout_pulse, bus_busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({drv_en, timeout_pulse} !== {4'b0000, 1'b0})
            $display("FAIL to_pulse_end: drv_en=%b tp=%b expected 0000 0", drv_en, timeout_pulse);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({grant, owner_id} !== {4'b0100, 2'd2})
            $display("FAIL to_next_owner: grant=%b owner=%0d expected 0100 2", grant, owner_id);
        else pass_cnt++;
        // Sole requester is never forced off.
        req = 4'b0100;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (drv_en !== 4'b0100 || timeout_pulse !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL to_sole_hold: %0d bad cycles expected 0", bad);
        else pass_cnt++;
`else
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (drv_en !== 4'b0001 || timeout_pulse !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL no_timeout_hold: %0d bad cycles expected 0", bad);
        else pass_cnt++;
`endif
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_contention();
        int         bad_onehot, bad_gap, bad_match, grants, zero_run;
        logic [3:0] prev_en;
        bit         seen;
        bad_onehot = 0; bad_gap = 0; bad_match = 0; grants = 0;
        zero_run   = 0; prev_en = 4'b0000; seen = 1'b0;
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            req = 4'($urandom);
            step();
            if (!$onehot0(drv_en)) bad_onehot++;
            if (grant !== drv_en) bad_match++;
            if (drv_en != 4'b0000) begin
                if (prev_en != 4'b0000 && prev_en != drv_en) bad_gap++;
                if (prev_en == 4'b0000) begin
                    if (seen && zero_run < 2) bad_gap++;
                    grants++;
                end
                seen     = 1'b1;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            prev_en = drv_en;
        end
        total_cnt++;
        if (bad_onehot !== 0)
            $display("FAIL rand_onehot: %0d violations expected 0", bad_onehot);
        else pass_cnt++;
        total_cnt++;
        if (bad_gap !== 0)
            $display("FAIL rand_gap: %0d violations expected 0", bad_gap);
        else pass_cnt++;
        total_cnt++;
        if (bad_match !== 0)
            $display("FAIL rand_grant_eq_en: %0d violations expected 0", bad_match);
        else pass_cnt++;
        total_cnt++;
        if (grants < 100)
            $display("FAIL rand_activity: %0d grants expected at least 100", grants);
        else pass_cnt++;
        req = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_reset_mid_own();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_contention();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
